// File: rtl/range_result_fifo_if.sv
// Handshake bundle between an upstream range finder, the result FIFO and its consumer.
// The master side produces range results and drains the head; the slave side is the FIFO.
interface range_result_fifo_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [WIDTH-1:0] peak;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  out_valid, out_data, count, overflow, peak
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output out_valid, out_data, count, overflow, peak
  );
endinterface

// File: rtl/range_result_fifo.sv
// First-word-fall-through FIFO for range results with a sticky drop flag and a running
// peak of every accepted result. A full FIFO still accepts a result when its head leaves.
module range_result_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input logic                  clock,
  input logic                  reset,
  range_result_fifo_if.slave   bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic [WIDTH-1:0] peak_q;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Pop may free the slot a push needs, so push depends on pop within the same cycle.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FULL_COUNT);
    pop   = !empty && bus.out_ready;
    push  = bus.in_valid && (!full || pop);
    drop  = bus.in_valid && !push;
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.peak      = peak_q;

  // NOTE: storage has no reset; pointers and count alone decide what is visible.
  always_ff @(posedge clock) begin
    if (push && !bus.clear) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural binary roll-over.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      peak_q     <= '0;
    end else if (bus.clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      peak_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (push && (bus.in_data > peak_q)) begin
        peak_q <= bus.in_data;
      end
    end
  end
endmodule

// File: tb/tb_range_result_fifo.sv
// Scoreboard bench for range_result_fifo: stimulus predicts accepted results into a queue,
// a monitor pops and compares each head entry as it is consumed.
module tb_range_result_fifo;
  localparam int WIDTH = 12;
  localparam int DEPTH = 4;

  logic clock;
  logic reset;

  range_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  range_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_peak = '0;
  bit               m_ovf  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the next edge whenever the head is offered, taken and not flushed.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && bus.out_valid && bus.out_ready && !bus.clear) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'(bus.out_data), 32'hDEAD);
        end else begin
          check("pop_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // One clock of stimulus; the model is the plain queue of accepted results.
  task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit rdy, input bit clr);
    bit m_pop;
    bit m_push;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.clear     = clr;
    m_pop  = (exp_q.size() != 0) && rdy && !clr;
    m_push = v && !clr && ((exp_q.size() < DEPTH) || m_pop);
    @(posedge clock);
    #1;
    if (clr) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_peak = '0;
    end else begin
      if (m_push) begin
        exp_q.push_back(d);
        if (d > m_peak) m_peak = d;
      end
      if (v && !m_push) m_ovf = 1'b1;
    end
    check("count", 32'(bus.count), 32'(exp_q.size()));
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("peak", 32'(bus.peak), 32'(m_peak));
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.clear     = 1'b0;
    reset         = 1'b0;
    #12;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single push becomes visible one cycle later.
    cycle(1'b1, 12'h123, 1'b0, 1'b0);
    check("single_data", 32'(bus.out_data), 32'h123);
    check("single_peak", 32'(bus.peak), 32'h123);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Order and pointer wrap.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 12'(i * 16), 1'b0, 1'b0);
    drain();
    cycle(1'b1, 12'h050, 1'b0, 1'b0);
    cycle(1'b1, 12'h060, 1'b0, 1'b0);
    drain();
    check("wrap_count", 32'(bus.count), 32'd0);

    // Full with simultaneous push and pop: no drop, new result emerges last.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 12'(i * 16), 1'b0, 1'b0);
    cycle(1'b1, 12'h0AA, 1'b1, 1'b0);
    check("fullpp_count", 32'(bus.count), 32'd4);
    check("fullpp_ovf", 32'(bus.overflow), 32'd0);
    drain();

    // Overflow: dropped result leaves count, peak and contents alone.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 12'(i * 16), 1'b0, 1'b0);
    cycle(1'b1, 12'hFFF, 1'b0, 1'b0);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_peak", 32'(bus.peak), 32'h0AA);
    drain();
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Clear wins over push and pop.
    cycle(1'b1, 12'h300, 1'b0, 1'b0);
    cycle(1'b1, 12'h100, 1'b0, 1'b0);
    check("pre_clear_peak", 32'(bus.peak), 32'h300);
    cycle(1'b1, 12'h7FF, 1'b1, 1'b1);
    check("clear_count", 32'(bus.count), 32'd0);
    check("clear_peak", 32'(bus.peak), 32'd0);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) cycle(1'b1, 12'(i + 5), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_count", 32'(bus.count), 32'd0);
    check("async_overflow", 32'(bus.overflow), 32'd0);
    check("async_peak", 32'(bus.peak), 32'd0);
    exp_q.delete();
    m_ovf  = 1'b0;
    m_peak = '0;
    @(negedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 6, 12'($urandom_range(0, 4095)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/range_result_fifo.md
RANGE_RESULT_FIFO -- requirements
Module: range_result_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data width of each range result.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries (power of two, >= 2).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port in_valid  input  1  upstream range finder presents a completed range result this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  range result (max - min) from upstream.
REQ-007 SHALL have port clear  input  1  synchronous flush of contents, flags and peak.
REQ-008 SHALL have port out_ready  input  1  downstream can accept the head entry this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry is valid.
REQ-010 SHALL have port out_data  output  WIDTH  head entry (first-word-fall-through).
REQ-011 SHALL have port count  output  clog2(DEPTH+1)  number of stored entries.
REQ-012 SHALL have port overflow  output  1  sticky flag: at least one result was dropped.
REQ-013 SHALL have port peak  output  WIDTH  largest result accepted since reset or clear.

Function
REQ-014 SHALL define push = in_valid AND (count < DEPTH OR pop), with pop = out_valid AND out_ready.
REQ-015 SHALL write in_data at the write pointer on push; write pointer increments modulo DEPTH.
REQ-016 SHALL advance the read pointer on pop, modulo DEPTH; pointers wrap with no gap.
REQ-017 SHALL keep out_valid = (count != 0) and out_data = entry at read pointer, both combinational from registered state.
REQ-018 SHALL make a pushed entry visible at out_valid/out_data in the cycle after the push edge (1-cycle latency, no same-cycle bypass when empty).
REQ-019 SHALL update count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-020 SHALL, when full with pop in the same cycle, accept the push (count stays DEPTH).
REQ-021 SHALL, when full without pop and in_valid=1, drop in_data, leave contents unchanged, and set overflow to 1.
REQ-022 SHALL hold overflow at 1 until reset or clear.
REQ-023 SHALL ignore out_ready when empty; no pointer change, out_data value don't-care but stable.
REQ-024 SHALL update peak on push only: peak <= max(peak, in_data), unsigned compare; dropped results do not affect peak.
REQ-025 SHALL, on clear=1, set count, pointers, overflow, peak to 0 at the next edge, with clear taking priority over push and pop that cycle.
REQ-026 SHALL not modify storage contents on clear (only pointers reset); stale data never becomes visible since out_valid=0.

Reset
REQ-027 SHALL, while reset=0, force count=0, both pointers=0, overflow=0, peak=0, hence out_valid=0, independent of clock.
REQ-028 SHALL resume normal operation on the first rising clock edge after reset returns to 1; storage array need not be reset.
REQ-029 SHALL discard all stored entries when reset asserts mid-operation, including any push or pop in that cycle.

Verification
REQ-030 Single push: in_valid=1, in_data=0x123 for one cycle, out_ready=0 -> next cycle out_valid=1, out_data=0x123, count=1, peak=0x123.
REQ-031 Order and wrap: push 0x010,0x020,0x030,0x040, pop all, push 0x050,0x060, pop all -> outputs 0x010..0x060 in order, count returns to 0.
REQ-032 Overflow: fill with 4 entries, push 0xFFF with out_ready=0 -> count=4, overflow=1, peak unchanged, 0xFFF never appears at out_data.
REQ-033 Full push+pop: full with head 0x010, in_valid=1 in_data=0x0AA, out_ready=1 -> count stays 4, overflow=0, 0x0AA emerges last after the three remaining entries.
REQ-034 Clear priority: count=2, overflow=1, peak=0x300; assert clear with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, overflow=0, peak=0.
REQ-035 Async reset: hold count=3, drive reset=0 between clock edges -> out_valid, count, overflow, peak go to 0 immediately, before the next edge.
